// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: sequential PC generation, req/ack instruction
// memory interface, prefetch FIFO and a flushing redirect port.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  output logic                     instr_valid,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  output logic [31:0]              instr_pcplus4,
  input  logic                     instr_ready,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]      r_fetch_pc;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_instr_mem [DEPTH];
  logic [31:0]      r_pc_mem    [DEPTH];

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_head_instr;
  logic [31:0] w_head_pc;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // Request depends only on registered occupancy, so a pop while full only
  // re-opens fetching on the following cycle.
  assign imem_req  = !rst && !w_full;
  assign imem_addr = r_fetch_pc;

  assign instr_valid = !rst && !w_empty;
  assign fifo_count  = rst ? '0 : r_count;

  assign w_push = imem_req && imem_ack && !redirect;
  assign w_pop  = instr_valid && instr_ready && !redirect;

  assign w_head_instr = r_instr_mem[r_rd_ptr];
  assign w_head_pc    = r_pc_mem[r_rd_ptr];

  // Head data is forced to zero while empty so that nothing stale or
  // uninitialised leaks out after reset or a flush.
  always_comb begin
    instr         = '0;
    instr_pc      = '0;
    instr_pcplus4 = '0;
    if (instr_valid) begin
      instr         = w_head_instr;
      instr_pc      = w_head_pc;
      instr_pcplus4 = w_head_pc + 32'd4;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (redirect) begin
      r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; validity is carried entirely by
  // r_count, and leaving it unreset lets it map onto plain register files.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= imem_rdata;
      r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by a
// randomized phase, all compared against a queue-based reference model.
module tb_instr_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] XORK     = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pcplus4;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  fifo_count;

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of fetched PCs plus the next fetch address.
  logic [31:0] m_q [$];
  logic [31:0] m_fetch;

  // Memory model state: wait states per request (negative means random).
  int          mem_waits;
  int          mem_cnt;
  logic        prev_req;
  logic        prev_ack;
  logic [31:0] prev_addr;

  instr_fetch_unit #(
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_pcplus4(instr_pcplus4),
    .instr_ready  (instr_ready),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ XORK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: called at a falling edge with inputs already driven.
  task automatic tick();
    logic        s_ack;
    logic        e_req;
    logic        e_valid;
    logic        s_rst;
    logic        s_redir;
    logic        s_ready;
    logic [31:0] s_rpc;
    #1;
    if (imem_req && prev_req && imem_addr == prev_addr && !prev_ack) mem_cnt++;
    else mem_cnt = 0;
    if (mem_waits < 0) s_ack = imem_req && ($urandom_range(0, 2) != 0);
    else               s_ack = imem_req && (mem_cnt >= mem_waits);
    imem_ack  = s_ack;
    prev_req  = imem_req;
    prev_addr = imem_addr;
    prev_ack  = s_ack;
    #1;
    e_req   = !rst && (m_q.size() < DEPTH);
    e_valid = !rst && (m_q.size() > 0);
    chk("imem_req", 32'(imem_req), 32'(e_req));
    chk("instr_valid", 32'(instr_valid), 32'(e_valid));
    chk("fifo_count", 32'(fifo_count), rst ? 32'd0 : 32'(m_q.size()));
    if (e_req) chk("imem_addr", imem_addr, m_fetch);
    if (e_valid) begin
      chk("instr_pc", instr_pc, m_q[0]);
      chk("instr", instr, m_q[0] ^ XORK);
      chk("instr_pcplus4", instr_pcplus4, m_q[0] + 32'd4);
    end
    s_rst   = rst;
    s_redir = redirect;
    s_ready = instr_ready;
    s_rpc   = redirect_pc;
    @(posedge clk);
    if (s_rst) begin
      m_q.delete();
      m_fetch = RESET_PC;
    end else if (s_redir) begin
      m_q.delete();
      m_fetch = s_rpc & 32'hFFFF_FFFC;
    end else begin
      if (e_valid && s_ready) void'(m_q.pop_front());
      if (e_req && s_ack) begin
        m_q.push_back(m_fetch);
        m_fetch = m_fetch + 32'd4;
      end
    end
    @(negedge clk);
    imem_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ack    = 1'b0;
    mem_waits   = 0;
    mem_cnt     = 0;
    prev_req    = 1'b0;
    prev_ack    = 1'b0;
    prev_addr   = '0;
    m_fetch     = RESET_PC;
    @(negedge clk);

    // Reset state and release.
    do_reset();
    #1;
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_pcplus4", instr_pcplus4, 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);

    // Streaming with zero-wait memory.
    instr_ready = 1'b1;
    tick();
    #1;
    chk("t1_valid", 32'(instr_valid), 32'd1);
    chk("t1_pc", instr_pc, 32'd0);
    chk("t1_pcplus4", instr_pcplus4, 32'd4);
    repeat (10) tick();

    // Fill and stall, then a single pop.
    do_reset();
    repeat (6) tick();
    #1;
    chk("t2_count", 32'(fifo_count), 32'd4);
    chk("t2_req", 32'(imem_req), 32'd0);
    chk("t2_addr", imem_addr, 32'd16);
    chk("t2_head", instr_pc, 32'd0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    #1;
    chk("t2_req_after_pop", 32'(imem_req), 32'd1);
    chk("t2_addr_after_pop", imem_addr, 32'd16);
    repeat (3) tick();

    // Three wait states per fetch.
    do_reset();
    mem_waits   = 3;
    instr_ready = 1'b1;
    repeat (20) tick();
    #1;
    chk("t3_addr", imem_addr, 32'd20);

    // Redirect with three entries buffered and an ack in the same cycle.
    do_reset();
    mem_waits = 0;
    repeat (3) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    #1;
    chk("t4_count", 32'(fifo_count), 32'd0);
    chk("t4_valid", 32'(instr_valid), 32'd0);
    chk("t4_addr", imem_addr, 32'h0000_0100);
    tick();
    #1;
    chk("t4_first_pc", instr_pc, 32'h0000_0100);
    instr_ready = 1'b1;
    repeat (4) tick();

    // Address wrap-around.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tick();
    #1;
    chk("t5_pc0", instr_pc, 32'hFFFF_FFFC);
    chk("t5_pcplus4", instr_pcplus4, 32'h0000_0000);
    tick();
    #1;
    chk("t5_pc1", instr_pc, 32'h0000_0000);
    repeat (3) tick();

    // Reset with two buffered entries and a request pending.
    do_reset();
    instr_ready = 1'b0;
    repeat (2) tick();
    mem_waits = 3;
    tick();
    rst = 1'b1;
    tick();
    #1;
    chk("t6_req", 32'(imem_req), 32'd0);
    chk("t6_valid", 32'(instr_valid), 32'd0);
    chk("t6_count", 32'(fifo_count), 32'd0);
    chk("t6_instr", instr, 32'd0);
    chk("t6_addr", imem_addr, 32'd0);
    rst = 1'b0;
    mem_waits = 0;
    #1;
    chk("t6_addr_release", imem_addr, RESET_PC);
    repeat (3) tick();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0) begin
        case ($urandom_range(0, 3))
          0:       mem_waits = -1;
          1:       mem_waits = 0;
          2:       mem_waits = 1;
          default: mem_waits = 3;
        endcase
      end
      instr_ready = 1'($urandom_range(0, 1));
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst      = 1'b0;
    redirect = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
